// File: rtl/vc_credit_scheduler.sv
// Per-VC credit tracking and wormhole output scheduler (priority + round-robin); optional aging via VC_CREDIT_SCHED_AGING_EN.
// Request to out_valid in 1 cycle; stalls with the lock held while out_ready, vc_req or credit of the locked VC is low.
module vc_credit_scheduler #(
   parameter int VC_NUM       = 4,
   parameter int PRIO_WIDTH   = 2,
   parameter int CREDIT_MAX   = 16,
   parameter int STARVE_LIMIT = 8,
   localparam int VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   localparam int CW = $clog2(CREDIT_MAX + 1)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [VC_NUM-1:0]            vc_req,
   input  logic [VC_NUM*PRIO_WIDTH-1:0] vc_prio,
   input  logic [VC_NUM-1:0]            vc_tail,
   output logic [VC_NUM-1:0]            grant,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [VW-1:0]                out_vc,
   input  logic [VC_NUM-1:0]            credit_ret,
   output logic [VC_NUM*CW-1:0]         credit_cnt,
   output logic                         credit_err,
   output logic                         busy
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOCK = 1'b1;

   logic [0:0]            state;
   logic [VW-1:0]         sel_vc;
   logic [VW-1:0]         rr_ptr;
   logic [VW-1:0]         win_idx;
   logic [VW-1:0]         next_rr;
   logic                  win_found;
   logic                  fire;
   logic [PRIO_WIDTH:0]   key;
   logic [PRIO_WIDTH:0]   win_key;
   logic [VC_NUM-1:0]     elig;
   logic [VC_NUM-1:0]     aged;
   logic [CW-1:0]         cnt  [VC_NUM];
   logic [PRIO_WIDTH-1:0] prio [VC_NUM];

   for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
      assign prio[i]                  = vc_prio[i*PRIO_WIDTH +: PRIO_WIDTH];
      assign elig[i]                  = vc_req[i] && (cnt[i] != '0);
      assign credit_cnt[i*CW +: CW]   = cnt[i];
   end

   // Circular scan from rr_ptr; only a strictly higher key displaces the current winner,
   // so ties fall to the first eligible VC at or after rr_ptr. The aged bit sits above priority.
   always_comb begin
      int idx;
      idx       = 0;
      key       = '0;
      win_key   = '0;
      win_idx   = '0;
      win_found = 1'b0;
      for (int k = 0; k < VC_NUM; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= VC_NUM) idx = idx - VC_NUM;
         key = {aged[idx], prio[idx]};
         if (elig[idx] && (!win_found || key > win_key)) begin
            win_found = 1'b1;
            win_idx   = idx[VW-1:0];
            win_key   = key;
         end
      end
   end

   assign out_valid = (state == LOCK) && vc_req[sel_vc] && (cnt[sel_vc] != '0);
   assign fire      = out_valid && out_ready;
   assign busy      = (state == LOCK);
   assign out_vc    = sel_vc;
   assign next_rr   = (sel_vc == VW'(VC_NUM - 1)) ? '0 : sel_vc + 1'b1;

   always_comb begin
      grant = '0;
      if (fire) grant[sel_vc] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         sel_vc <= '0;
         rr_ptr <= '0;
      end else begin
         case (state)
            IDLE: if (win_found) begin
               sel_vc <= win_idx;
               state  <= LOCK;
            end
            default: if (fire && vc_tail[sel_vc]) begin
               state  <= IDLE;
               rr_ptr <= next_rr;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         credit_err <= 1'b0;
         for (int i = 0; i < VC_NUM; i++) cnt[i] <= CW'(CREDIT_MAX);
      end else begin
         for (int i = 0; i < VC_NUM; i++) begin
            case ({grant[i], credit_ret[i]})
               2'b10:   cnt[i] <= cnt[i] - 1'b1;
               2'b01:   if (cnt[i] == CW'(CREDIT_MAX)) credit_err <= 1'b1;
                        else cnt[i] <= cnt[i] + 1'b1;
               default: ;
            endcase
         end
      end
   end

`ifdef VC_CREDIT_SCHED_AGING_EN
   localparam int AW = $clog2(STARVE_LIMIT + 1);
   logic [AW-1:0] age [VC_NUM];

   for (genvar i = 0; i < VC_NUM; i++) begin : g_aged
      assign aged[i] = (age[i] == AW'(STARVE_LIMIT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < VC_NUM; i++) age[i] <= '0;
      end else if (state == IDLE && win_found) begin
         for (int i = 0; i < VC_NUM; i++) begin
            if (VW'(i) == win_idx) age[i] <= '0;
            else if (elig[i] && !aged[i]) age[i] <= age[i] + 1'b1;
         end
      end
   end
`else
   assign aged = '0;
`endif

endmodule
